ikaopll_acc_i2s_tx: RTL and testbench

- Sink for the accumulation DAC output of the OPLL core.
- Captures each 16-bit signed accumulated sample on the rising edge of its strobe. Applies a saturating gain shift and buffers the result in a small FIFO.
- Serializes samples as 16-bit stereo I2S, with the same mono sample on both channels, for an external codec.
- Sits between the core's DAC stage and the board audio pins.

---
 rtl/ikaopll_acc_i2s_tx_if.sv | 50 +++++
 rtl/ikaopll_acc_i2s_tx.sv | 171 +++++++++++++++++
 tb/tb_ikaopll_acc_i2s_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ikaopll_acc_i2s_tx_if.sv
// +----------------------------------------------------------------------------+
// | ikaopll_acc_i2s_tx_if                                                      |
// | Sample-in / I2S-out signal bundle for the OPLL accumulation DAC sink.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface ikaopll_acc_i2s_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic signed [15:0]   i_ACC_SIGNED;
    logic                 i_ACC_SIGNED_STRB;
    logic                 i_FLAG_CLR;
    logic                 o_I2S_BCLK;
    logic                 o_I2S_LRCK;
    logic                 o_I2S_SDATA;
    logic [c_LEVEL_W-1:0] o_FIFO_LEVEL;
    logic                 o_OVERFLOW;
    logic                 o_UNDERRUN;

    // Core / board side: drives samples and flag clear, observes the I2S pins.
    modport master (
        output i_ACC_SIGNED,
        output i_ACC_SIGNED_STRB,
        output i_FLAG_CLR,
        input  o_I2S_BCLK,
        input  o_I2S_LRCK,
        input  o_I2S_SDATA,
        input  o_FIFO_LEVEL,
        input  o_OVERFLOW,
        input  o_UNDERRUN
    );

    modport slave (
        input  i_ACC_SIGNED,
        input  i_ACC_SIGNED_STRB,
        input  i_FLAG_CLR,
        output o_I2S_BCLK,
        output o_I2S_LRCK,
        output o_I2S_SDATA,
        output o_FIFO_LEVEL,
        output o_OVERFLOW,
        output o_UNDERRUN
    );
endinterface

`default_nettype wire

// File: rtl/ikaopll_acc_i2s_tx.sv
// +----------------------------------------------------------------------------+
// | ikaopll_acc_i2s_tx                                                         |
// | Captures OPLL accumulated samples, applies saturating gain, buffers them   |
// | and serializes each as a mono 16-bit stereo I2S frame.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ikaopll_acc_i2s_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4,
    parameter int GAIN_SHIFT = 0
) (
    input  wire logic           i_EMUCLK,
    input  wire logic           i_RST,
    ikaopll_acc_i2s_tx_if.slave bus
);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LEVEL_W = c_PTR_W + 1;
    localparam int c_DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
    localparam logic [c_LEVEL_W-1:0] c_FULL     = c_LEVEL_W'(FIFO_DEPTH);

    // Serializer state
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic                 bclk_q, bclk_d;
    logic                 started_q, started_d;
    logic [4:0]           bitcnt_q, bitcnt_d;
    logic                 lrck_q, lrck_d;
    logic                 sdata_q, sdata_d;
    logic [15:0]          held_q, held_d;

    // Capture and FIFO state
    logic                 strb_z_q, strb_z_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_LEVEL_W-1:0] level_q, level_d;
    logic [15:0]          mem_q [FIFO_DEPTH];
    logic [15:0]          mem_d [FIFO_DEPTH];
    logic                 primed_q, primed_d;
    logic                 overflow_q, overflow_d;
    logic                 underrun_q, underrun_d;

    logic                 w_div_wrap;
    logic                 w_bclk_fall;
    logic                 w_frame_start;
    logic                 w_push;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic signed [20:0]   w_sample_wide;
    logic [15:0]          w_sample_sat;
    logic [3:0]           w_bit_idx;

    always_comb begin
        // Bit clock divider; every falling BCLK edge opens a new slot.
        w_div_wrap  = (div_q == c_DIV_LAST);
        w_bclk_fall = w_div_wrap & bclk_q;
        div_d       = w_div_wrap ? '0 : div_q + 1'b1;
        bclk_d      = w_div_wrap ? ~bclk_q : bclk_q;
        started_d   = started_q | w_bclk_fall;

        bitcnt_d = bitcnt_q;
        if (w_bclk_fall) begin
            bitcnt_d = started_q ? bitcnt_q + 5'd1 : 5'd0;
        end
        w_frame_start = w_bclk_fall && (bitcnt_d == 5'd0);

        // Gain shift on a sign-extended copy, then clamp to 16-bit range.
        w_sample_wide = $signed({{5{bus.i_ACC_SIGNED[15]}}, bus.i_ACC_SIGNED}) <<< GAIN_SHIFT;
        if (w_sample_wide > 21'sd32767) begin
            w_sample_sat = 16'h7FFF;
        end else if (w_sample_wide < -21'sd32768) begin
            w_sample_sat = 16'h8000;
        end else begin
            w_sample_sat = w_sample_wide[15:0];
        end

        strb_z_d     = bus.i_ACC_SIGNED_STRB;
        w_push       = bus.i_ACC_SIGNED_STRB & ~strb_z_q;
        w_fifo_empty = (level_q == '0);
        w_fifo_full  = (level_q == c_FULL);
        w_pop_ok     = w_frame_start & ~w_fifo_empty;
        // A full FIFO still accepts a push when a pop frees a slot this cycle.
        w_push_ok    = w_push & (~w_fifo_full | w_pop_ok);

        wr_ptr_d = w_push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        mem_d = mem_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = w_sample_sat;
        end

        held_d   = w_pop_ok ? mem_q[rd_ptr_q] : held_q;
        primed_d = primed_q | w_push_ok;

        // Set events take priority over a simultaneous clear.
        overflow_d = (w_push & ~w_push_ok) | (overflow_q & ~bus.i_FLAG_CLR);
        underrun_d = (w_frame_start & w_fifo_empty & primed_q)
                   | (underrun_q & ~bus.i_FLAG_CLR);

        // One-bit I2S delay: slot k carries bit (16-k) mod 16 of the held word,
        // so slot 0 still shows bit 0 of the word held before this frame's pop.
        lrck_d    = lrck_q;
        sdata_d   = sdata_q;
        w_bit_idx = 4'd0 - bitcnt_d[3:0];
        if (w_bclk_fall) begin
            lrck_d  = bitcnt_d[4];
            sdata_d = held_q[w_bit_idx];
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            started_q  <= 1'b0;
            bitcnt_q   <= 5'd0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            held_q     <= 16'h0000;
            strb_z_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            started_q  <= started_d;
            bitcnt_q   <= bitcnt_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            held_q     <= held_d;
            strb_z_q   <= strb_z_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            primed_q   <= primed_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_EMUCLK) begin
        mem_q <= mem_d;
    end

    assign bus.o_I2S_BCLK   = bclk_q;
    assign bus.o_I2S_LRCK   = lrck_q;
    assign bus.o_I2S_SDATA  = sdata_q;
    assign bus.o_FIFO_LEVEL = level_q;
    assign bus.o_OVERFLOW   = overflow_q;
    assign bus.o_UNDERRUN   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ikaopll_acc_i2s_tx.sv
// +----------------------------------------------------------------------------+
// | tb_ikaopll_acc_i2s_tx                                                      |
// | Directed bench for the accumulation-DAC I2S transmitter (gain 0 and 2).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ikaopll_acc_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] acc = 16'h0000;
    logic        strb = 1'b0;
    logic        clr = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] c_LR = 32'hFFFF_0000;

    ikaopll_acc_i2s_tx_if #(.FIFO_DEPTH(4)) bus0 ();
    ikaopll_acc_i2s_tx_if #(.FIFO_DEPTH(4)) bus2 ();

    assign bus0.i_ACC_SIGNED      = acc;
    assign bus0.i_ACC_SIGNED_STRB = strb;
    assign bus0.i_FLAG_CLR        = clr;
    assign bus2.i_ACC_SIGNED      = acc;
    assign bus2.i_ACC_SIGNED_STRB = strb;
    assign bus2.i_FLAG_CLR        = clr;

    ikaopll_acc_i2s_tx #(.FIFO_DEPTH(4), .BCLK_DIV(4), .GAIN_SHIFT(0)) dut (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .bus      (bus0.slave)
    );

    ikaopll_acc_i2s_tx #(.FIFO_DEPTH(4), .BCLK_DIV(4), .GAIN_SHIFT(2)) dut_g (
        .i_EMUCLK (clk),
        .i_RST    (rst),
        .bus      (bus2.slave)
    );

    always #5 clk = ~clk;

    // Edges since reset release; frame f slot k begins at edge 8 + 256*f + 8*k.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // I2S slot image of sample s whose frame follows a frame that held p.
    function automatic logic [31:0] exp_frame(input logic [15:0] s, input logic [15:0] p);
        logic [31:0] r;
        r[0]  = p[0];
        for (int k = 1; k <= 15; k++) r[k] = s[16-k];
        r[16] = s[0];
        for (int k = 17; k <= 31; k++) r[k] = s[32-k];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; strb = 1'b0; clr = 1'b0; acc = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 4000 && cyc != target; i++) @(negedge clk);
        total++;
        if (cyc != target) begin
            bad++;
            $display("FAIL wait_cyc: got cyc %0d want %0d", cyc, target);
        end
    endtask

    task automatic pulse_strobe(input logic [15:0] v, input int hold);
        acc  = v;
        strb = 1'b1;
        repeat (hold) @(negedge clk);
        strb = 1'b0;
        @(negedge clk);
    endtask

    // Samples the middle of each slot of the next frame on both DUTs.
    task automatic get_frame(output logic [31:0] sd0, output logic [31:0] lr0,
                             output logic [31:0] sd2);
        for (int i = 0; i < 600 && !(cyc >= 12 && ((cyc - 12) % 256) == 0); i++)
            @(negedge clk);
        total++;
        if (!(cyc >= 12 && ((cyc - 12) % 256) == 0)) begin
            bad++;
            $display("FAIL frame_sync: got cyc %0d want slot-0 midpoint", cyc);
        end
        for (int k = 0; k < 32; k++) begin
            sd0[k] = bus0.o_I2S_SDATA;
            lr0[k] = bus0.o_I2S_LRCK;
            sd2[k] = bus2.o_I2S_SDATA;
            if (k < 31) repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] sd0, lr0, sd2;
        do_reset();
        total++;
        if ({bus0.o_I2S_BCLK, bus0.o_I2S_LRCK, bus0.o_I2S_SDATA, bus0.o_OVERFLOW,
             bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got bclk%b lrck%b sd%b ovf%b und%b lvl%0d want all 0",
                     bus0.o_I2S_BCLK, bus0.o_I2S_LRCK, bus0.o_I2S_SDATA, bus0.o_OVERFLOW,
                     bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus0.o_I2S_BCLK !== 1'b0) begin
            bad++; $display("FAIL reset_bclk_c3: got %b want 0", bus0.o_I2S_BCLK);
        end
        @(negedge clk);
        total++;
        if (bus0.o_I2S_BCLK !== 1'b1) begin
            bad++; $display("FAIL reset_bclk_c4: got %b want 1", bus0.o_I2S_BCLK);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd0 !== 32'h0) begin
            bad++; $display("FAIL reset_frame0_sd: got %h want 00000000", sd0);
        end
        total++;
        if (lr0 !== c_LR) begin
            bad++; $display("FAIL reset_frame0_lr: got %h want %h", lr0, c_LR);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if ({bus0.o_OVERFLOW, bus0.o_UNDERRUN} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: got %b want 00", {bus0.o_OVERFLOW, bus0.o_UNDERRUN});
        end
    endtask

    task automatic test_basic();
        logic [31:0] sd0, lr0, sd2;
        do_reset();
        pulse_strobe(16'h8001, 3);
        total++;
        if (bus0.o_FIFO_LEVEL !== 3'd1) begin
            bad++; $display("FAIL basic_level1: got %0d want 1", bus0.o_FIFO_LEVEL);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd0 !== exp_frame(16'h8001, 16'h0000)) begin
            bad++; $display("FAIL basic_frame0: got %h want %h", sd0, exp_frame(16'h8001, 16'h0000));
        end
        total++;
        if (lr0 !== c_LR) begin
            bad++; $display("FAIL basic_lr: got %h want %h", lr0, c_LR);
        end
        total++;
        if (bus0.o_FIFO_LEVEL !== 3'd0) begin
            bad++; $display("FAIL basic_level0: got %0d want 0", bus0.o_FIFO_LEVEL);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd0 !== exp_frame(16'h8001, 16'h8001)) begin
            bad++; $display("FAIL basic_frame1: got %h want %h", sd0, exp_frame(16'h8001, 16'h8001));
        end
    endtask

    task automatic test_gain();
        logic [31:0] sd0, lr0, sd2;
        do_reset();
        pulse_strobe(16'h2000, 3);
        pulse_strobe(16'hD000, 3);
        pulse_strobe(16'h0100, 3);
        total++;
        if (bus2.o_FIFO_LEVEL !== 3'd2) begin
            bad++; $display("FAIL gain_level: got %0d want 2", bus2.o_FIFO_LEVEL);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd2 !== exp_frame(16'h7FFF, 16'h0000)) begin
            bad++; $display("FAIL gain_sat_pos: got %h want %h", sd2, exp_frame(16'h7FFF, 16'h0000));
        end
        total++;
        if (sd0 !== exp_frame(16'h2000, 16'h0000)) begin
            bad++; $display("FAIL gain0_pass: got %h want %h", sd0, exp_frame(16'h2000, 16'h0000));
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd2 !== exp_frame(16'h8000, 16'h7FFF)) begin
            bad++; $display("FAIL gain_sat_neg: got %h want %h", sd2, exp_frame(16'h8000, 16'h7FFF));
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd2 !== exp_frame(16'h0400, 16'h8000)) begin
            bad++; $display("FAIL gain_shift: got %h want %h", sd2, exp_frame(16'h0400, 16'h8000));
        end
    endtask

    task automatic test_overflow();
        logic [31:0] sd0, lr0, sd2;
        logic [15:0] smp [5];
        logic [15:0] prev;
        smp = '{16'h5A5A, 16'h1357, 16'hA5A5, 16'h0F0F, 16'h7777};
        do_reset();
        wait_cyc(20);
        pulse_strobe(smp[0], 9);
        total++;
        if (bus0.o_FIFO_LEVEL !== 3'd1) begin
            bad++; $display("FAIL hold_one_push: got %0d want 1", bus0.o_FIFO_LEVEL);
        end
        for (int i = 1; i < 4; i++) pulse_strobe(smp[i], 3);
        total++;
        if ({bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL ovf_fill: got ovf%b lvl%0d want ovf0 lvl4", bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL);
        end
        pulse_strobe(smp[4], 3);
        total++;
        if ({bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL} !== {1'b1, 3'd4}) begin
            bad++; $display("FAIL ovf_drop: got ovf%b lvl%0d want ovf1 lvl4", bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL);
        end
        prev = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            get_frame(sd0, lr0, sd2);
            total++;
            if (sd0 !== exp_frame(smp[i], prev)) begin
                bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, sd0, exp_frame(smp[i], prev));
            end
            prev = smp[i];
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd0 !== exp_frame(smp[3], smp[3])) begin
            bad++; $display("FAIL ovf_dropped_absent: got %h want %h", sd0, exp_frame(smp[3], smp[3]));
        end
    endtask

    task automatic test_underrun();
        logic [31:0] sd0, lr0, sd2;
        do_reset();
        pulse_strobe(16'h1234, 3);
        get_frame(sd0, lr0, sd2);
        total++;
        if (bus0.o_UNDERRUN !== 1'b0) begin
            bad++; $display("FAIL und_before: got %b want 0", bus0.o_UNDERRUN);
        end
        get_frame(sd0, lr0, sd2);
        total++;
        if (sd0 !== exp_frame(16'h1234, 16'h1234)) begin
            bad++; $display("FAIL und_repeat: got %h want %h", sd0, exp_frame(16'h1234, 16'h1234));
        end
        total++;
        if (bus0.o_UNDERRUN !== 1'b1) begin
            bad++; $display("FAIL und_set: got %b want 1", bus0.o_UNDERRUN);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (bus0.o_UNDERRUN !== 1'b0) begin
            bad++; $display("FAIL und_clear: got %b want 0", bus0.o_UNDERRUN);
        end
        wait_cyc(519);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (bus0.o_UNDERRUN !== 1'b1) begin
            bad++; $display("FAIL und_set_wins: got %b want 1", bus0.o_UNDERRUN);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sd0, lr0, sd2;
        logic [15:0] smp [5];
        logic [15:0] prev;
        smp = '{16'h0001, 16'hC003, 16'h3C3C, 16'h8421, 16'hFFFE};
        do_reset();
        wait_cyc(20);
        for (int i = 0; i < 4; i++) pulse_strobe(smp[i], 3);
        total++;
        if (bus0.o_FIFO_LEVEL !== 3'd4) begin
            bad++; $display("FAIL b2b_fill: got %0d want 4", bus0.o_FIFO_LEVEL);
        end
        wait_cyc(263);
        acc  = smp[4];
        strb = 1'b1;
        @(negedge clk);
        total++;
        if ({bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL b2b_pushpop: got ovf%b lvl%0d want ovf0 lvl4", bus0.o_OVERFLOW, bus0.o_FIFO_LEVEL);
        end
        repeat (2) @(negedge clk);
        strb = 1'b0;
        prev = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            get_frame(sd0, lr0, sd2);
            total++;
            if (sd0 !== exp_frame(smp[i], prev)) begin
                bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, sd0, exp_frame(smp[i], prev));
            end
            prev = smp[i];
        end
        wait_cyc(1560);
        pulse_strobe(16'h4321, 3);
        total++;
        if ({bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL} !== {1'b1, 3'd1}) begin
            bad++; $display("FAIL b2b_premid: got und%b lvl%0d want und1 lvl1", bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL);
        end
        wait_cyc(1628);
        total++;
        if (bus0.o_I2S_BCLK !== 1'b1) begin
            bad++; $display("FAIL mid_bclk_high: got %b want 1", bus0.o_I2S_BCLK);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus0.o_I2S_BCLK, bus0.o_I2S_LRCK, bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL} !== 6'h00) begin
            bad++; $display("FAIL mid_reset: got bclk%b lrck%b und%b lvl%0d want all 0",
                            bus0.o_I2S_BCLK, bus0.o_I2S_LRCK, bus0.o_UNDERRUN, bus0.o_FIFO_LEVEL);
        end
        rst = 1'b0;
        get_frame(sd0, lr0, sd2);
        total++;
        if ({sd0, lr0} !== {32'h0, c_LR}) begin
            bad++; $display("FAIL post_reset_frame: got sd%h lr%h want sd00000000 lr%h", sd0, lr0, c_LR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gain();
        test_overflow();
        test_underrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
